panda_regfile_wb_arbiter: RTL
=============================

Name: panda_regfile_wb_arbiter

Overview:
Write-back controller for panda_register_file's single write port (rd_addr/rd_data/rd_we).
- After reset, sequences a clear of x1..x(NumRegs-1) to zero.
- Then shares the write port between the execute stage (EX) and the load/store unit (LSU) using round-robin valid/ready arbitration.
- Sits between the pipeline write-back sources and the register file.

Parameters:
NumRegs, 32, number of architectural registers; address width AW = $clog2(NumRegs)
DataWidth, 32, register data width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous, active-high reset
ex_valid_i  in  1  EX write-back request
ex_ready_o  out  1  EX request accepted this cycle
ex_rd_addr_i  in  AW  EX destination register
ex_rd_data_i  in  DataWidth  EX write data
lsu_valid_i  in  1  LSU write-back request
lsu_ready_o  out  1  LSU request accepted this cycle
lsu_rd_addr_i  in  AW  LSU destination register
lsu_rd_data_i  in  DataWidth  LSU write data
rd_addr_o  out  AW  register file write address
rd_data_o  out  DataWidth  register file write data
rd_we_o  out  1  register file write enable
init_done_o  out  1  clear sequence finished; arbitration active
conflict_cnt_o  out  16  cycles in which both sources were valid (see Optional Feature)

Behaviour:
Reset:
- rst_i is sampled at clk_i; takes effect at the next edge, including mid-operation.
- Reset values: rd_we_o=0, rd_addr_o=0, rd_data_o=0, init_done_o=0, conflict_cnt_o=0, state=INIT, clear counter=1, last_grant=LSU.
- Any registered write is discarded.
- ex_ready_o and lsu_ready_o are 0 whenever state!=RUN.

State machine INIT -> RUN (no other transitions except reset):
- INIT: each edge with rst_i=0 registers rd_we_o=1, rd_addr_o=counter, rd_data_o=0, then increments counter.
- The edge that registers address NumRegs-1 also moves the state to RUN.
- The clear therefore covers NumRegs-1 consecutive cycles; x0 is never written.
- init_done_o is registered and rises on the edge after the last clear write, together with the first RUN-cycle outputs.

RUN arbitration:
- ready outputs are combinational from the valid inputs and last_grant. No combinational path from rd_* outputs.
- Only one source valid: that source gets ready=1.
- Both sources valid: grant the source not in last_grant. last_grant updates on each accept.
- Neither valid: both readies are 0.
- A transfer occurs when valid && ready.
- A requester holds valid, addr and data stable until accepted; valid may drop only after acceptance.

Write output timing:
- Latency: the transfer at edge N drives rd_we_o/rd_addr_o/rd_data_o during cycle N+1.
- rd_we_o=0 in any RUN cycle following no transfer; rd_addr_o and rd_data_o hold their last values.
- Throughput: one write per cycle, with no bubbles under back-to-back requests.

Boundary cases:
- Address 0: the request is accepted (ready=1) but rd_we_o stays 0. last_grant still updates.
- Same address from both sources in one cycle: only the granted source writes; the other waits for the next cycle (ordering = grant order).
- Address >= NumRegs (non-power-of-2 NumRegs): the write is dropped, like x0.

Optional Feature:
Macro PANDA_WB_ARB_STATS_EN.
- Defined: conflict_cnt_o increments on each RUN cycle with ex_valid_i && lsu_valid_i, saturates at 16'hFFFF, and clears on reset.
- Undefined: conflict_cnt_o is tied to 0 and no counter flops are generated. The port exists in both builds.

Test Plan:
- Clear sequence: rst_i=1 for 2 cycles, then 0 with no valids -> rd_we_o=1 for 31 consecutive cycles, rd_addr_o=1..31 ascending, rd_data_o=0; init_done_o=1 on the following cycle; both readies 0 throughout INIT.
- Single EX write after init: ex_valid_i=1, addr=5, data=32'hDEADBEEF -> ex_ready_o=1 in the same cycle; next cycle rd_we_o=1, rd_addr_o=5, rd_data_o=32'hDEADBEEF; the cycle after, rd_we_o=0.
- Contention: both valid for 4 cycles, EX addr 3 / data 32'h33, LSU addr 4 / data 32'h44, each re-presenting after acceptance -> grants EX, LSU, EX, LSU; rd_addr_o sequence 3, 4, 3, 4 on consecutive cycles with rd_we_o=1.
- x0 drop: lsu_valid_i=1, addr=0, data=32'h1234 -> lsu_ready_o=1; rd_we_o stays 0 the next cycle; a following EX+LSU contention grants EX first.
- Reset mid-operation: EX transfer at edge N with rst_i=1 sampled at edge N -> rd_we_o=0 in cycle N+1, init_done_o=0; after rst_i=0 the clear restarts at rd_addr_o=1.
- Stats (PANDA_WB_ARB_STATS_EN defined): both valid for 10 RUN cycles -> conflict_cnt_o=10. With the counter preloaded near the limit (force to 16'hFFFE, 3 conflict cycles) -> holds at 16'hFFFF. Macro undefined -> conflict_cnt_o=0 always.

Source files
------------

// File: rtl/panda_regfile_wb_arbiter_if.sv
// Write-back bundle between the pipeline sources (EX, LSU) and the register-file write port.
// The slave modport is the arbiter's view; the master modport is the pipeline/register-file side.
interface panda_regfile_wb_arbiter_if #(
  parameter int unsigned NumRegs   = 32,
  parameter int unsigned DataWidth = 32
);
  localparam int unsigned AW = (NumRegs > 1) ? $clog2(NumRegs) : 1;

  logic                 ex_valid_i;
  logic                 ex_ready_o;
  logic [AW-1:0]        ex_rd_addr_i;
  logic [DataWidth-1:0] ex_rd_data_i;
  logic                 lsu_valid_i;
  logic                 lsu_ready_o;
  logic [AW-1:0]        lsu_rd_addr_i;
  logic [DataWidth-1:0] lsu_rd_data_i;
  logic [AW-1:0]        rd_addr_o;
  logic [DataWidth-1:0] rd_data_o;
  logic                 rd_we_o;
  logic                 init_done_o;
  logic [15:0]          conflict_cnt_o;

  modport slave (
    input  ex_valid_i, ex_rd_addr_i, ex_rd_data_i,
    input  lsu_valid_i, lsu_rd_addr_i, lsu_rd_data_i,
    output ex_ready_o, lsu_ready_o,
    output rd_addr_o, rd_data_o, rd_we_o, init_done_o, conflict_cnt_o
  );

  modport master (
    output ex_valid_i, ex_rd_addr_i, ex_rd_data_i,
    output lsu_valid_i, lsu_rd_addr_i, lsu_rd_data_i,
    input  ex_ready_o, lsu_ready_o,
    input  rd_addr_o, rd_data_o, rd_we_o, init_done_o, conflict_cnt_o
  );
endinterface

// File: rtl/panda_regfile_wb_arbiter.sv
// Register-file write-back controller: clears x1..x(NumRegs-1) after reset, then round-robins
// the write port between EX and LSU. Define PANDA_WB_ARB_STATS_EN to enable the conflict counter.
module panda_regfile_wb_arbiter #(
  parameter int unsigned NumRegs   = 32,
  parameter int unsigned DataWidth = 32
) (
  input logic                       clk_i,
  input logic                       rst_i,
  panda_regfile_wb_arbiter_if.slave bus
);
  localparam int unsigned AW = (NumRegs > 1) ? $clog2(NumRegs) : 1;

  typedef enum logic {StInit, StRun} state_e;
  typedef enum logic {GrantEx, GrantLsu} grant_e;

  state_e               state_q, state_d;
  grant_e               last_grant_q, last_grant_d;
  logic [AW-1:0]        clr_cnt_q, clr_cnt_d;
  logic                 rd_we_q, rd_we_d;
  logic [AW-1:0]        rd_addr_q, rd_addr_d;
  logic [DataWidth-1:0] rd_data_q, rd_data_d;
  logic                 init_done_q, init_done_d;
  logic                 ex_ready, lsu_ready;

  // x0 and addresses beyond the register count are accepted but never written.
  function automatic logic addr_writable(input logic [AW-1:0] addr);
    return (addr != '0) && (32'(addr) < NumRegs);
  endfunction

  always_comb begin
    ex_ready  = 1'b0;
    lsu_ready = 1'b0;
    if (state_q == StRun) begin
      case ({bus.ex_valid_i, bus.lsu_valid_i})
        2'b10:   ex_ready = 1'b1;
        2'b01:   lsu_ready = 1'b1;
        2'b11: begin
          if (last_grant_q == GrantLsu) ex_ready = 1'b1;
          else                          lsu_ready = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    clr_cnt_d    = clr_cnt_q;
    rd_we_d      = 1'b0;
    rd_addr_d    = rd_addr_q;
    rd_data_d    = rd_data_q;
    init_done_d  = init_done_q;
    unique case (state_q)
      StInit: begin
        rd_we_d   = 1'b1;
        rd_addr_d = clr_cnt_q;
        rd_data_d = '0;
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == AW'(NumRegs - 1)) state_d = StRun;
      end
      StRun: begin
        // First RUN cycle still shows the final clear write; done rises one edge later.
        init_done_d = 1'b1;
        if (ex_ready) begin
          rd_we_d      = addr_writable(bus.ex_rd_addr_i);
          rd_addr_d    = bus.ex_rd_addr_i;
          rd_data_d    = bus.ex_rd_data_i;
          last_grant_d = GrantEx;
        end else if (lsu_ready) begin
          rd_we_d      = addr_writable(bus.lsu_rd_addr_i);
          rd_addr_d    = bus.lsu_rd_addr_i;
          rd_data_d    = bus.lsu_rd_data_i;
          last_grant_d = GrantLsu;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StInit;
      last_grant_q <= GrantLsu;
      clr_cnt_q    <= AW'(1);
      rd_we_q      <= 1'b0;
      rd_addr_q    <= '0;
      rd_data_q    <= '0;
      init_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      clr_cnt_q    <= clr_cnt_d;
      rd_we_q      <= rd_we_d;
      rd_addr_q    <= rd_addr_d;
      rd_data_q    <= rd_data_d;
      init_done_q  <= init_done_d;
    end
  end

`ifdef PANDA_WB_ARB_STATS_EN
  logic [15:0] conflict_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      conflict_cnt_q <= '0;
    end else if (state_q == StRun && bus.ex_valid_i && bus.lsu_valid_i &&
                 conflict_cnt_q != 16'hFFFF) begin
      conflict_cnt_q <= conflict_cnt_q + 16'd1;
    end
  end

  assign bus.conflict_cnt_o = conflict_cnt_q;
`else
  assign bus.conflict_cnt_o = '0;
`endif

  assign bus.ex_ready_o  = ex_ready;
  assign bus.lsu_ready_o = lsu_ready;
  assign bus.rd_we_o     = rd_we_q;
  assign bus.rd_addr_o   = rd_addr_q;
  assign bus.rd_data_o   = rd_data_q;
  assign bus.init_done_o = init_done_q;
endmodule
